jk_excitation_driver: RTL

Drives a bank of WIDTH external JK flip-flops to a requested target state. Target words arrive over a valid/ready handshake. Each bit's J/K pair comes from the JK excitation table, applied against a shadow copy of the bank state. The block sits between a register-programming controller and the JK flop bank, and converts "desired Q" into "J/K drive". The flop bank shares `clk` and `rst_n` with this block.

---
 rtl/jk_exc_pkg.sv | 9 +
 rtl/jk_excitation_cell.sv | 16 +
 rtl/jk_excitation_driver.sv | 86 ++++++++
 3 files changed

// File: rtl/jk_exc_pkg.sv
// jk_exc_pkg: shared FSM states and J/K excitation codes for the JK bank driver
package jk_exc_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  typedef logic [1:0] jk_t;
  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_SET    = 2'b10;
  localparam jk_t JK_RESET  = 2'b01;
  localparam jk_t JK_TOGGLE = 2'b11;
endpackage

// File: rtl/jk_excitation_cell.sv
// jk_excitation_cell: one-bit JK excitation lookup, shadow s -> target t
module jk_excitation_cell
  import jk_exc_pkg::*;
#(
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic s,
  input  logic t,
  output logic j,
  output logic k
);
  jk_t jk;
  // a changing bit uses toggle or explicit set/reset depending on preference
  always_comb jk = (s == t) ? JK_HOLD : TOGGLE_PREF ? JK_TOGGLE : t ? JK_SET : JK_RESET;
  assign {j, k} = jk;
endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns requested Q words into one-cycle J/K drive; readback check under JK_READBACK_CHECK_EN
module jk_excitation_driver
  import jk_exc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  input  logic             err_clr
);
  state_t state, next;
  logic [WIDTH-1:0] exc_j, exc_k;
  logic accept;
  assign accept = tgt_valid && tgt_ready && (state == IDLE);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      jk_excitation_cell #(.TOGGLE_PREF(TOGGLE_PREF)) u_cell (
        .s(shadow_q[i]),
        .t(tgt_data[i]),
        .j(exc_j[i]),
        .k(exc_k[i])
      );
    end
  endgenerate
  // next state: IDLE -> DRIVE on handshake, DRIVE -> CHECK when checking, everything else back to IDLE
  always_comb begin
    next = IDLE;
    if (state == IDLE && accept) next = DRIVE;
`ifdef JK_READBACK_CHECK_EN
    else if (state == DRIVE) next = CHECK;
`endif
  end
  // state, handshake/status flags, J/K drive and the shadow copy of the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      j_out     <= '0;
      k_out     <= '0;
      shadow_q  <= '0;
    end else begin
      state     <= next;
      tgt_ready <= next == IDLE;
      busy      <= next != IDLE;
      done      <= (state != IDLE) && (next == IDLE);
      j_out     <= accept ? exc_j : '0;
      k_out     <= accept ? exc_k : '0;
      shadow_q  <= (state == DRIVE) ? ((j_out & ~shadow_q) | (~k_out & shadow_q)) : shadow_q;
    end
  end
`ifdef JK_READBACK_CHECK_EN
  // readback compare in CHECK; clear wins over a same-cycle mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_bits <= '0;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_bits <= '0;
    end else if (state == CHECK) begin
      err_bits <= q_in ^ shadow_q;
      err      <= err | (|(q_in ^ shadow_q));
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{q_in, err_clr};
  assign err           = 1'b0;
  assign err_bits      = '0;
`endif
endmodule
